multi_wave_dds: RTL and testbench

MULTI_WAVE_DDS -- requirements
Module: multi_wave_dds

---
 rtl/multi_wave_dds_if.sv | 29 ++
 rtl/multi_wave_dds.sv | 130 +++++++++++++
 tb/tb_multi_wave_dds.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/multi_wave_dds_if.sv
// Control, config and sample bus for the multi-channel DDS.
// The master drives phase advance and config writes; the slave returns samples.
interface multi_wave_dds_if #(
  parameter int CH = 2,
  parameter int DW = 8,
  parameter int PW = 16
);
  logic          en;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [1:0]    cfg_addr;
  logic [PW-1:0] cfg_wdata;
  logic          mix_avg;
  logic [DW-1:0] dout;
  logic          out_valid;
  logic [CH-1:0] wrap;

  modport master (
    output en, cfg_we, cfg_ch, cfg_addr,
    output cfg_wdata, mix_avg,
    input  dout, out_valid, wrap
  );

  modport slave (
    input  en, cfg_we, cfg_ch, cfg_addr,
    input  cfg_wdata, mix_avg,
    output dout, out_valid, wrap
  );
endinterface

// File: rtl/multi_wave_dds.sv
// Multi-channel DDS: per-channel phase accumulators, four waveforms,
// amplitude scaling and a saturating/averaging mixer, 3-stage pipeline.
module multi_wave_dds #(
  parameter int CH = 2,
  parameter int DW = 8,
  parameter int PW = 16
) (
  input logic            clk,
  input logic            rst_n,
  multi_wave_dds_if.slave bus
);
  localparam int SW = $clog2(CH);
  localparam logic [DW-2:0] HMAX = '1;
  localparam logic [DW+1:0] SMAX = {2'b00, {DW{1'b1}}};

  logic [PW-1:0] acc    [CH];
  logic [PW-1:0] fw     [CH];
  logic [2:0]    mode   [CH];
  logic [DW-1:0] amp    [CH];
  logic [DW-1:0] wave_q [CH];
  logic [DW-1:0] scl_q  [CH];

  logic [PW-1:0] acc_d  [CH];
  logic [DW-1:0] wave_d [CH];
  logic [DW-1:0] scl_d  [CH];
  logic [CH-1:0] carry;
  logic [CH-1:0] load;
  logic [CH-1:0] sel;

  logic [CH-1:0] wrap_q;
  logic [2:0]    vld_q;
  logic [DW-1:0] dout_q;
  logic [DW+1:0] mix_sum;
  logic [DW-1:0] dout_d;

  always_comb begin
    logic [DW-1:0]   u;
    logic [DW-2:0]   x;
    logic [DW-2:0]   nx;
    logic [DW-2:0]   h;
    logic [2*DW-3:0] sq;
    logic [2*DW-3:0] sq_sh;
    logic [2*DW-1:0] wq;
    logic [2*DW-1:0] ap;
    logic [2*DW-1:0] ps;
    u     = '0;
    x     = '0;
    nx    = '0;
    h     = '0;
    sq    = '0;
    sq_sh = '0;
    wq    = '0;
    ap    = '0;
    ps    = '0;
    for (int c = 0; c < CH; c++) begin
      sel[c]  = bus.cfg_we && (bus.cfg_ch == 2'(c));
      load[c] = sel[c] && (bus.cfg_addr == 2'd3);
      {carry[c], acc_d[c]} = {1'b0, acc[c]} + {1'b0, fw[c]};
      u  = acc[c][PW-1 -: DW];
      x  = u[DW-2:0];
      nx = ~x;
      // x*(2^(DW-1)-1-x) is a parabola peaking mid-quadrant
      sq    = (2*DW-2)'(x) * (2*DW-2)'(nx);
      sq_sh = sq >> (DW-3);
      h     = (sq_sh > (2*DW-2)'(HMAX)) ? HMAX : (DW-1)'(sq_sh);
      wave_d[c] = '0;
      unique case (mode[c][1:0])
        2'd0: wave_d[c] = u;
        2'd1: wave_d[c] = u[DW-1] ? '0 : '1;
        2'd2: wave_d[c] = u[DW-1] ? ~{x, 1'b0} : {x, 1'b0};
        2'd3: wave_d[c] = u[DW-1] ? {1'b0, ~h} : {1'b1, h};
      endcase
      if (!mode[c][2]) wave_d[c] = '0;
      wq = (2*DW)'(wave_q[c]);
      ap = (2*DW)'(amp[c]) + (2*DW)'(1);
      ps = wq * ap;
      scl_d[c] = DW'(ps >> DW);
    end
  end

  always_comb begin
    mix_sum = '0;
    for (int c = 0; c < CH; c++)
      mix_sum = mix_sum + (DW+2)'(scl_q[c]);
    if (bus.mix_avg)
      dout_d = DW'(mix_sum >> SW);
    else
      dout_d = (mix_sum > SMAX) ? '1 : DW'(mix_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        acc[c]    <= '0;
        fw[c]     <= '0;
        mode[c]   <= '0;
        amp[c]    <= '1;
        wave_q[c] <= '0;
        scl_q[c]  <= '0;
      end
      wrap_q <= '0;
      vld_q  <= '0;
      dout_q <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (load[c])
          acc[c] <= bus.cfg_wdata;
        else if (bus.en)
          acc[c] <= acc_d[c];
        wrap_q[c] <= bus.en && carry[c] && !load[c];
        if (sel[c]) begin
          unique case (bus.cfg_addr)
            2'd0:    fw[c]   <= bus.cfg_wdata;
            2'd1:    mode[c] <= bus.cfg_wdata[2:0];
            2'd2:    amp[c]  <= bus.cfg_wdata[DW-1:0];
            default: ;
          endcase
        end
        wave_q[c] <= wave_d[c];
        scl_q[c]  <= scl_d[c];
      end
      vld_q  <= {vld_q[1:0], bus.en};
      dout_q <= dout_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.out_valid = vld_q[2];
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_multi_wave_dds.sv
// Randomized and directed bench for multi_wave_dds against a
// behavioural model built from the waveform/mixer arithmetic.
module tb_multi_wave_dds;
  localparam int CH = 2;
  localparam int DW = 8;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_wave_dds_if #(.CH(CH), .DW(DW), .PW(PW)) bus ();

  multi_wave_dds #(.CH(CH), .DW(DW), .PW(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int m_acc  [CH];
  int m_fw   [CH];
  int m_mode [CH];
  int m_amp  [CH];
  int m_wrap [CH];
  int acc_h  [3][CH];
  int en_h   [3];
  int stable;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wave_ref(int u, int wf);
    int x;
    int h;
    bit m;
    m = (u >= 128);
    x = u % 128;
    case (wf)
      0: return u;
      1: return m ? 0 : 255;
      2: return m ? 255 - 2 * x : 2 * x;
      default: begin
        h = (x * (127 - x)) / 32;
        if (h > 127) h = 127;
        return m ? 127 - h : 128 + h;
      end
    endcase
  endfunction

  function automatic int exp_dout();
    int s;
    int w;
    s = 0;
    for (int c = 0; c < CH; c++) begin
      w = 0;
      if (((m_mode[c] >> 2) & 1) == 1)
        w = wave_ref(acc_h[2][c] / 256, m_mode[c] % 4);
      s += (w * (m_amp[c] + 1)) / 256;
    end
    if (bus.mix_avg) return s / 2;
    return (s > 255) ? 255 : s;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_acc[c]  = 0;
      m_fw[c]   = 0;
      m_mode[c] = 0;
      m_amp[c]  = 255;
      m_wrap[c] = 0;
      for (int k = 0; k < 3; k++) acc_h[k][c] = 0;
    end
    for (int k = 0; k < 3; k++) en_h[k] = 0;
    stable = 0;
  endtask

  task automatic set_mix(bit v);
    bus.mix_avg = v;
    stable = 0;
  endtask

  // one clock: drive at negedge, advance model, check at next negedge
  task automatic cycle(bit en, bit we = 1'b0, int ch = 0,
                       int addr = 0, int wdata = 0);
    int s;
    bus.en        = en;
    bus.cfg_we    = we;
    bus.cfg_ch    = 2'(ch);
    bus.cfg_addr  = 2'(addr);
    bus.cfg_wdata = 16'(wdata);
    for (int c = 0; c < CH; c++) begin
      acc_h[2][c] = acc_h[1][c];
      acc_h[1][c] = acc_h[0][c];
      acc_h[0][c] = m_acc[c];
    end
    en_h[2] = en_h[1];
    en_h[1] = en_h[0];
    en_h[0] = en;
    for (int c = 0; c < CH; c++) begin
      if (we && ch == c && addr == 3) begin
        m_acc[c]  = wdata % 65536;
        m_wrap[c] = 0;
      end else if (en) begin
        s = m_acc[c] + m_fw[c];
        m_wrap[c] = (s > 65535) ? 1 : 0;
        m_acc[c]  = s % 65536;
      end else begin
        m_wrap[c] = 0;
      end
      if (we && ch == c) begin
        if (addr == 0) m_fw[c] = wdata % 65536;
        if (addr == 1) begin m_mode[c] = wdata % 8; stable = 0; end
        if (addr == 2) begin m_amp[c] = wdata % 256; stable = 0; end
      end
    end
    stable++;
    @(posedge clk);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    for (int c = 0; c < CH; c++)
      check($sformatf("wrap%0d", c), 32'(bus.wrap[c]), 32'(m_wrap[c]));
    check("valid", 32'(bus.out_valid), 32'(en_h[2]));
    if (stable >= 4)
      check("dout", 32'(bus.dout), 32'(exp_dout()));
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    bus.en = 1'b0;
    bus.cfg_we = 1'b0;
    #1;
    check("rst_dout", 32'(bus.dout), 32'h0);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_wrap", 32'(bus.wrap), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.en = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_ch = '0;
    bus.cfg_addr = '0;
    bus.cfg_wdata = '0;
    bus.mix_avg = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("init_dout", 32'(bus.dout), 32'h0);
    check("init_valid", 32'(bus.out_valid), 32'h0);
    check("init_wrap", 32'(bus.wrap), 32'h0);
    rst_n = 1'b1;

    // saw on ch0, 256-cycle wrap period
    cycle(0, 1, 0, 0, 'h0100);
    cycle(0, 1, 0, 1, 4);
    repeat (600) cycle(1);

    // triangle / sine at fixed phases
    cycle(0, 1, 0, 1, 6);
    cycle(0, 1, 0, 3, 'h4000);
    repeat (4) cycle(0);
    check("tri40", 32'(bus.dout), 32'h80);
    cycle(0, 1, 0, 3, 'hC000);
    repeat (4) cycle(0);
    check("triC0", 32'(bus.dout), 32'h7F);
    cycle(0, 1, 0, 1, 7);
    cycle(0, 1, 0, 3, 'h0000);
    repeat (4) cycle(0);
    check("sin00", 32'(bus.dout), 32'h80);
    cycle(0, 1, 0, 3, 'h4000);
    repeat (4) cycle(0);
    check("sin40", 32'(bus.dout), 32'hFE);
    cycle(0, 1, 0, 3, 'hC000);
    repeat (4) cycle(0);
    check("sinC0", 32'(bus.dout), 32'h01);

    // mixer saturation and averaging
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 0, 1, 4);
    cycle(0, 1, 1, 1, 4);
    cycle(0, 1, 0, 3, 'h8000);
    cycle(0, 1, 1, 3, 'h8000);
    set_mix(0);
    repeat (5) cycle(0);
    check("mix_sat", 32'(bus.dout), 32'hFF);
    set_mix(1);
    repeat (5) cycle(0);
    check("mix_avg", 32'(bus.dout), 32'h80);
    cycle(0, 1, 1, 2, 'h7F);
    repeat (5) cycle(0);
    check("mix_amp", 32'(bus.dout), 32'h60);
    set_mix(0);

    // phase load while running, and load masking a carry
    cycle(0, 1, 1, 0, 'h0100);
    cycle(0, 1, 0, 0, 'h0100);
    cycle(1, 1, 1, 3, 'h1234);
    repeat (6) cycle(1);
    cycle(0, 1, 0, 3, 'hFF80);
    cycle(1, 1, 0, 3, 'h0010);
    repeat (6) cycle(1);

    // en gap of 5 cycles
    repeat (10) cycle(1);
    repeat (5) cycle(0);
    repeat (10) cycle(1);

    // reset while streaming
    do_reset();
    cycle(0, 1, 0, 0, 'h0300);
    cycle(0, 1, 0, 1, 5);
    repeat (12) cycle(1);

    // random traffic, including writes to absent channels
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) set_mix(1'($urandom_range(0, 1)));
      cycle($urandom_range(0, 3) != 0,
            $urandom_range(0, 5) == 0,
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 65535)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
